// File: rtl/factor_pkg.sv
// Shared types and helpers for the factorization game's player-entry block.
package factor_pkg;

    localparam logic [3:0] INPUT_STATE = 4'd1;

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        DONE    = 2'd2
    } phase_t;

    // Arithmetic conversion: illegal BCD digits are weighted as-is and the sum is truncated to 10 bits.
    function automatic logic [9:0] bcd3_to_bin(input logic [11:0] bcd);
        logic [13:0] sum;
        sum = 14'(bcd[11:8]) * 14'd100 + 14'(bcd[7:4]) * 14'd10 + 14'(bcd[3:0]);
        return sum[9:0];
    endfunction

endpackage

// File: rtl/factor_input_if.sv
// Button inputs, question number and display/result outputs of the player-entry block.
interface factor_input_if;
    logic [3:0]  STATE;
    logic [2:0]  SEL;
    logic        DEC;
    logic        CLR;
    logic [23:0] QUESTION;
    logic [3:0]  SEG1, SEG2, SEG3, SEG4, SEG5, SEG6;
    logic [3:0]  SEG1_Q, SEG2_Q, SEG3_Q;
    logic [3:0]  COUNT1_OUT, COUNT2_OUT, COUNT3_OUT;
    logic        LED;
    logic        QUE_OK;

    modport master (
        output STATE, SEL, DEC, CLR, QUESTION,
        input  SEG1, SEG2, SEG3, SEG4, SEG5, SEG6, SEG1_Q, SEG2_Q, SEG3_Q,
        input  COUNT1_OUT, COUNT2_OUT, COUNT3_OUT, LED, QUE_OK
    );

    modport slave (
        input  STATE, SEL, DEC, CLR, QUESTION,
        output SEG1, SEG2, SEG3, SEG4, SEG5, SEG6, SEG1_Q, SEG2_Q, SEG3_Q,
        output COUNT1_OUT, COUNT2_OUT, COUNT3_OUT, LED, QUE_OK
    );
endinterface

// File: rtl/bcd_digit_counter.sv
// Single BCD digit counter: increments 0..9 with wrap, clear has priority.
module bcd_digit_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] count
);
    logic [3:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= 4'd0;
        end else if (clr) begin
            count_reg <= 4'd0;
        end else if (inc) begin
            count_reg <= (count_reg == 4'd9) ? 4'd0 : count_reg + 4'd1;
        end
    end

    assign count = count_reg;
endmodule

// File: rtl/factor_input.sv
// Player entry: builds two 3-digit BCD factors from button edges and verifies A*B against the question.
module factor_input #(
    parameter logic [3:0] INPUT_STATE = factor_pkg::INPUT_STATE
) (
    input  logic           CLK,
    input  logic           RST,
    factor_input_if.slave  bus
);
    import factor_pkg::phase_t;
    import factor_pkg::ENTER_A;
    import factor_pkg::ENTER_B;
    import factor_pkg::DONE;
    import factor_pkg::bcd3_to_bin;

    logic [2:0]  sel_prev_reg;
    logic        dec_prev_reg, clr_prev_reg;
    phase_t      phase_reg, phase_next;
    logic [11:0] slot_a_reg, slot_a_next, slot_b_reg, slot_b_next;
    logic        led_reg, led_next, que_ok_reg, que_ok_next;
    logic [2:0]  cnt_inc;
    logic        cnt_clr;
    logic [3:0]  count [3];

    logic        active, dec_rise, clr_rise, correct;
    logic [2:0]  sel_rise;
    logic [11:0] entry;
    logic [9:0]  a_bin, b_bin, n_bin;
    logic        unused_question;

    assign active   = (bus.STATE == INPUT_STATE);
    assign sel_rise = bus.SEL & ~sel_prev_reg;
    assign dec_rise = bus.DEC & ~dec_prev_reg;
    assign clr_rise = bus.CLR & ~clr_prev_reg;
    assign entry    = {count[0], count[1], count[2]};

    // B is verified from the live entry digits in the same cycle it is committed.
    assign a_bin   = bcd3_to_bin(slot_a_reg);
    assign b_bin   = bcd3_to_bin(entry);
    assign n_bin   = bcd3_to_bin(bus.QUESTION[23:12]);
    assign correct = (a_bin >= 10'd2) && (b_bin >= 10'd2) &&
                     ((20'(a_bin) * 20'(b_bin)) == 20'(n_bin));
    assign unused_question = ^bus.QUESTION[11:0];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_digit
            bcd_digit_counter u_digit (
                .clk   (CLK),
                .rst_n (RST),
                .inc   (cnt_inc[gi]),
                .clr   (cnt_clr),
                .count (count[gi])
            );
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sel_prev_reg <= 3'd0;
            dec_prev_reg <= 1'b0;
            clr_prev_reg <= 1'b0;
            phase_reg    <= ENTER_A;
            slot_a_reg   <= 12'd0;
            slot_b_reg   <= 12'd0;
            led_reg      <= 1'b0;
            que_ok_reg   <= 1'b0;
        end else begin
            sel_prev_reg <= bus.SEL;
            dec_prev_reg <= bus.DEC;
            clr_prev_reg <= bus.CLR;
            phase_reg    <= phase_next;
            slot_a_reg   <= slot_a_next;
            slot_b_reg   <= slot_b_next;
            led_reg      <= led_next;
            que_ok_reg   <= que_ok_next;
        end
    end

    always_comb begin
        phase_next  = phase_reg;
        slot_a_next = slot_a_reg;
        slot_b_next = slot_b_reg;
        led_next    = led_reg;
        que_ok_next = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 3'd0;
        if (active) begin
            if (clr_rise) begin
                phase_next  = ENTER_A;
                slot_a_next = 12'd0;
                slot_b_next = 12'd0;
                led_next    = 1'b0;
                cnt_clr     = 1'b0 | 1'b1;
            end else if (dec_rise && phase_reg != DONE) begin
                cnt_clr = 1'b1;
                if (phase_reg == ENTER_A) begin
                    slot_a_next = entry;
                    phase_next  = ENTER_B;
                end else begin
                    slot_b_next = entry;
                    phase_next  = DONE;
                    led_next    = correct;
                    que_ok_next = correct;
                end
            end else if (phase_reg != DONE) begin
                cnt_inc = sel_rise;
            end
        end
    end

    assign bus.SEG1       = slot_a_reg[11:8];
    assign bus.SEG2       = slot_a_reg[7:4];
    assign bus.SEG3       = slot_a_reg[3:0];
    assign bus.SEG4       = slot_b_reg[11:8];
    assign bus.SEG5       = slot_b_reg[7:4];
    assign bus.SEG6       = slot_b_reg[3:0];
    assign bus.SEG1_Q     = bus.QUESTION[23:20];
    assign bus.SEG2_Q     = bus.QUESTION[19:16];
    assign bus.SEG3_Q     = bus.QUESTION[15:12];
    assign bus.COUNT1_OUT = count[0];
    assign bus.COUNT2_OUT = count[1];
    assign bus.COUNT3_OUT = count[2];
    assign bus.LED        = led_reg;
    assign bus.QUE_OK     = que_ok_reg;
endmodule

// File: tb/tb_factor_input.sv
// Self-checking bench for factor_input: directed scenarios plus randomized play against a digit-level model.
module tb_factor_input;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    factor_input_if bus();

    factor_input dut (.CLK(CLK), .RST(RST), .bus(bus));

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Model: digits, slots and phase expressed as plain integers.
    int m_cnt [3];
    int m_a [3];
    int m_b [3];
    int m_phase;
    int m_led, m_que;
    bit [2:0] m_sel_prev;
    bit m_dec_prev, m_clr_prev;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0; m_a[i] = 0; m_b[i] = 0;
        end
        m_phase = 0; m_led = 0; m_que = 0;
        m_sel_prev = 3'd0; m_dec_prev = 1'b0; m_clr_prev = 1'b0;
    endtask

    function automatic int digits_value(int h, int t, int o);
        return h * 100 + t * 10 + o;
    endfunction

    task automatic model_edge();
        bit [2:0] sel_r;
        bit dec_r, clr_r;
        int av, bv, nv;
        if (!RST) begin
            model_reset();
            return;
        end
        sel_r = bus.SEL & ~m_sel_prev;
        dec_r = bus.DEC && !m_dec_prev;
        clr_r = bus.CLR && !m_clr_prev;
        m_que = 0;
        if (bus.STATE == 4'd1) begin
            if (clr_r) begin
                for (int i = 0; i < 3; i++) begin
                    m_cnt[i] = 0; m_a[i] = 0; m_b[i] = 0;
                end
                m_led = 0; m_phase = 0;
            end else if (dec_r && m_phase < 2) begin
                if (m_phase == 0) begin
                    for (int i = 0; i < 3; i++) m_a[i] = m_cnt[i];
                    m_phase = 1;
                end else begin
                    for (int i = 0; i < 3; i++) m_b[i] = m_cnt[i];
                    av = digits_value(m_a[0], m_a[1], m_a[2]);
                    bv = digits_value(m_b[0], m_b[1], m_b[2]);
                    nv = digits_value(int'(bus.QUESTION[23:20]), int'(bus.QUESTION[19:16]),
                                      int'(bus.QUESTION[15:12])) % 1024;
                    m_led = (av >= 2 && bv >= 2 && av * bv == nv) ? 1 : 0;
                    m_que = m_led;
                    m_phase = 2;
                end
                for (int i = 0; i < 3; i++) m_cnt[i] = 0;
            end else if (m_phase < 2) begin
                for (int i = 0; i < 3; i++)
                    if (sel_r[i]) m_cnt[i] = (m_cnt[i] + 1) % 10;
            end
        end
        m_sel_prev = bus.SEL; m_dec_prev = bus.DEC; m_clr_prev = bus.CLR;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("COUNT1", 32'(bus.COUNT1_OUT), m_cnt[0]);
        chk("COUNT2", 32'(bus.COUNT2_OUT), m_cnt[1]);
        chk("COUNT3", 32'(bus.COUNT3_OUT), m_cnt[2]);
        chk("SEG1", 32'(bus.SEG1), m_a[0]);
        chk("SEG2", 32'(bus.SEG2), m_a[1]);
        chk("SEG3", 32'(bus.SEG3), m_a[2]);
        chk("SEG4", 32'(bus.SEG4), m_b[0]);
        chk("SEG5", 32'(bus.SEG5), m_b[1]);
        chk("SEG6", 32'(bus.SEG6), m_b[2]);
        chk("SEG1_Q", 32'(bus.SEG1_Q), 32'(bus.QUESTION[23:20]));
        chk("SEG2_Q", 32'(bus.SEG2_Q), 32'(bus.QUESTION[19:16]));
        chk("SEG3_Q", 32'(bus.SEG3_Q), 32'(bus.QUESTION[15:12]));
        chk("LED", 32'(bus.LED), m_led);
        chk("QUE_OK", 32'(bus.QUE_OK), m_que);
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(logic [2:0] sel, logic dec, logic clr);
        bus.SEL = sel; bus.DEC = dec; bus.CLR = clr;
        tick();
    endtask

    task automatic press(logic [2:0] sel, logic dec, logic clr);
        drive(sel, dec, clr);
        drive(3'd0, 1'b0, 1'b0);
    endtask

    // Bring the live digits to the target using the model's current digits.
    task automatic enter(int h, int t, int o);
        int tgt [3];
        tgt[0] = h; tgt[1] = t; tgt[2] = o;
        for (int d = 0; d < 3; d++) begin
            int n;
            n = (tgt[d] - m_cnt[d] + 10) % 10;
            for (int k = 0; k < n; k++) press(3'(1 << d), 1'b0, 1'b0);
        end
    endtask

    function automatic logic [23:0] to_question(int n);
        logic [23:0] q;
        q = '0;
        q[23:20] = 4'((n / 100) % 10);
        q[19:16] = 4'((n / 10) % 10);
        q[15:12] = 4'(n % 10);
        q[11:0]  = 12'($urandom);
        return q;
    endfunction

    initial begin
        bus.STATE = 4'd0; bus.SEL = 3'd0; bus.DEC = 1'b0; bus.CLR = 1'b0;
        bus.QUESTION = 24'h000000;
        model_reset();
        repeat (2) tick();
        #3 RST = 1'b1;
        tick();
        chk("reset_led", 32'(bus.LED), 0);
        chk("reset_seg1", 32'(bus.SEG1), 0);

        // Entry with wrap, held level, and inactive state.
        bus.STATE = 4'd1;
        for (int k = 0; k < 11; k++) press(3'b001, 1'b0, 1'b0);
        chk("wrap_count1", 32'(bus.COUNT1_OUT), 1);
        repeat (4) drive(3'b010, 1'b0, 1'b0);
        drive(3'b000, 1'b0, 1'b0);
        chk("held_count2", 32'(bus.COUNT2_OUT), 1);
        bus.STATE = 4'd0;
        repeat (3) press(3'b111, 1'b0, 1'b0);
        chk("inactive_count1", 32'(bus.COUNT1_OUT), 1);
        chk("inactive_count3", 32'(bus.COUNT3_OUT), 0);
        bus.STATE = 4'd1;
        press(3'b000, 1'b0, 1'b1);

        // Correct answer 011 x 013 = 143.
        bus.QUESTION = 24'h143000;
        #1;
        chk("q_digit1", 32'(bus.SEG1_Q), 1);
        chk("q_digit2", 32'(bus.SEG2_Q), 4);
        chk("q_digit3", 32'(bus.SEG3_Q), 3);
        enter(0, 1, 1); press(3'b000, 1'b1, 1'b0);
        enter(0, 1, 3);
        drive(3'b000, 1'b1, 1'b0);
        chk("correct_que_ok", 32'(bus.QUE_OK), 1);
        chk("correct_led", 32'(bus.LED), 1);
        chk("correct_seg3", 32'(bus.SEG3), 1);
        chk("correct_seg6", 32'(bus.SEG6), 3);
        drive(3'b000, 1'b0, 1'b0);
        chk("que_ok_one_cycle", 32'(bus.QUE_OK), 0);

        // DONE lock, then clear.
        press(3'b111, 1'b1, 1'b0);
        chk("done_lock_led", 32'(bus.LED), 1);
        chk("done_lock_count1", 32'(bus.COUNT1_OUT), 0);
        bus.QUESTION = 24'h999000;
        tick();
        chk("done_no_reeval", 32'(bus.LED), 1);
        press(3'b000, 1'b0, 1'b1);
        chk("clr_led", 32'(bus.LED), 0);
        chk("clr_seg5", 32'(bus.SEG5), 0);

        // Wrong answers: trivial factor and wrong product.
        bus.QUESTION = 24'h143000;
        enter(0, 0, 1); press(3'b000, 1'b1, 1'b0);
        enter(1, 4, 3); press(3'b000, 1'b1, 1'b0);
        chk("trivial_led", 32'(bus.LED), 0);
        press(3'b000, 1'b0, 1'b1);
        enter(0, 1, 2); press(3'b000, 1'b1, 1'b0);
        enter(0, 1, 2); drive(3'b000, 1'b1, 1'b0);
        chk("wrong_que_ok", 32'(bus.QUE_OK), 0);
        chk("wrong_led", 32'(bus.LED), 0);
        press(3'b000, 1'b0, 1'b1);

        // CLR and DEC together in ENTER_B: clear wins, next DEC commits A.
        enter(0, 1, 1); press(3'b000, 1'b1, 1'b0);
        enter(0, 1, 3);
        press(3'b000, 1'b1, 1'b1);
        chk("prio_que_ok", 32'(bus.QUE_OK), 0);
        chk("prio_seg2", 32'(bus.SEG2), 0);
        enter(0, 2, 5); press(3'b000, 1'b1, 1'b0);
        chk("prio_phase_a", 32'(bus.SEG2), 2);
        chk("prio_seg6", 32'(bus.SEG6), 0);
        press(3'b000, 1'b0, 1'b1);

        // Randomized factor pairs with occasional inactive cycles.
        for (int r = 0; r < 25; r++) begin
            int a, b;
            a = int'($urandom_range(0, 40));
            b = int'($urandom_range(0, 999 / (a > 0 ? a : 1)));
            bus.QUESTION = to_question(($urandom_range(0, 2) == 0) ? a * b + 1 : a * b);
            enter(a / 100, (a / 10) % 10, a % 10);
            if ($urandom_range(0, 3) == 0) begin
                bus.STATE = 4'(2); press(3'b111, 1'b1, 1'b0); bus.STATE = 4'd1;
            end
            press(3'b000, 1'b1, 1'b0);
            enter(b / 100, (b / 10) % 10, b % 10);
            press(3'b000, 1'b1, 1'b0);
            press(3'($urandom), 1'b1, 1'b0);
            press(3'b000, 1'b0, 1'b1);
        end

        // Free-running random input soup, including illegal BCD questions.
        for (int c = 0; c < 400; c++) begin
            bus.STATE = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'd1;
            if ($urandom_range(0, 15) == 0) bus.QUESTION = 24'($urandom);
            drive(3'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 30) == 0));
        end

        // Asynchronous reset mid-operation.
        bus.STATE = 4'd1; bus.QUESTION = 24'h143000;
        press(3'b000, 1'b0, 1'b1);
        enter(0, 1, 1); press(3'b000, 1'b1, 1'b0);
        enter(3, 4, 5);
        chk("pre_reset_count1", 32'(bus.COUNT1_OUT), 3);
        #2 RST = 1'b0;
        #1;
        model_reset();
        chk("async_count1", 32'(bus.COUNT1_OUT), 0);
        chk("async_count3", 32'(bus.COUNT3_OUT), 0);
        chk("async_seg2", 32'(bus.SEG2), 0);
        chk("async_led", 32'(bus.LED), 0);
        tick();
        #3 RST = 1'b1;
        press(3'b100, 1'b0, 1'b0);
        chk("post_reset_count3", 32'(bus.COUNT3_OUT), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
